// File: rtl/icache_refill_unit_pkg.sv
// Shared frontend definitions: refill geometry and refill FSM encoding.
package icache_refill_unit_pkg;

   localparam int unsigned LINE_SIZE_DEF  = 512;
   localparam int unsigned BEAT_WIDTH_DEF = 64;
   localparam int unsigned ADDR_WIDTH_DEF = 64;
   localparam int unsigned MISS_CNT_W     = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } refill_state_t;

endpackage

// File: rtl/icache_refill_unit_if.sv
// Miss, refill, memory and status signals of the icache refill unit.
interface icache_refill_unit_if
   import icache_refill_unit_pkg::*;
#(
   parameter int unsigned LINE_SIZE  = LINE_SIZE_DEF,
   parameter int unsigned BEAT_WIDTH = BEAT_WIDTH_DEF,
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) ();

   logic                  icache_miss_valid_i;
   logic [ADDR_WIDTH-1:0] icache_miss_addr_i;
   logic                  refill_icache_valid_o;
   logic [LINE_SIZE-1:0]  refill_icache_data_o;
   logic                  mem_req_valid_o;
   logic                  mem_req_ready_i;
   logic [ADDR_WIDTH-1:0] mem_req_addr_o;
   logic                  mem_resp_valid_i;
   logic [BEAT_WIDTH-1:0] mem_resp_data_i;
   logic                  busy_o;
   logic [MISS_CNT_W-1:0] miss_cnt_o;

   // Refill unit side
   modport master (
      input  icache_miss_valid_i, icache_miss_addr_i,
      input  mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
      output refill_icache_valid_o, refill_icache_data_o,
      output mem_req_valid_o, mem_req_addr_o,
      output busy_o, miss_cnt_o
   );

   // Cache / memory side
   modport slave (
      output icache_miss_valid_i, icache_miss_addr_i,
      output mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
      input  refill_icache_valid_o, refill_icache_data_o,
      input  mem_req_valid_o, mem_req_addr_o,
      input  busy_o, miss_cnt_o
   );

endinterface

// File: rtl/icache_refill_unit.sv
// Fetches one cache line as BEATS single-outstanding memory beats and
// presents the assembled line with a one-cycle refill pulse.
module icache_refill_unit
   import icache_refill_unit_pkg::*;
#(
   parameter int unsigned LINE_SIZE  = LINE_SIZE_DEF,
   parameter int unsigned BEAT_WIDTH = BEAT_WIDTH_DEF,
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input logic           clk,
   input logic           rst,
   icache_refill_unit_if.master bus
);

   localparam int unsigned BEATS      = LINE_SIZE / BEAT_WIDTH;
   localparam int unsigned LINE_BYTES = LINE_SIZE / 8;
   localparam int unsigned BEAT_SHIFT = $clog2(BEAT_WIDTH / 8);
   localparam int unsigned CNT_W      = $clog2(BEATS);

   refill_state_t         state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [CNT_W-1:0]      beat_q, beat_d;
   logic [LINE_SIZE-1:0]  line_q, line_d;
   logic [LINE_SIZE-1:0]  data_q, data_d;
   logic [MISS_CNT_W-1:0] cnt_q, cnt_d;
   logic                  req_valid_q, req_valid_d;
   logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
   logic                  refill_valid_q, refill_valid_d;
   logic                  last_beat;

   assign last_beat = (beat_q == CNT_W'(BEATS - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (bus.icache_miss_valid_i) state_d = REQ;
         REQ:  if (bus.mem_req_ready_i)     state_d = WAIT;
         WAIT: if (bus.mem_resp_valid_i)    state_d = last_beat ? DONE : REQ;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of the datapath and the registered outputs
   always_comb begin
      base_d = base_q;
      beat_d = beat_q;
      line_d = line_q;
      data_d = data_q;
      cnt_d  = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.icache_miss_valid_i) begin
               base_d = bus.icache_miss_addr_i & ~ADDR_WIDTH'(LINE_BYTES - 1);
               beat_d = '0;
               if (cnt_q != '1) cnt_d = cnt_q + MISS_CNT_W'(1);
            end
         end
         WAIT: begin
            if (bus.mem_resp_valid_i) begin
               for (int unsigned k = 0; k < BEATS; k++) begin
                  if (beat_q == CNT_W'(k)) line_d[k*BEAT_WIDTH +: BEAT_WIDTH] = bus.mem_resp_data_i;
               end
               // Counter parks on the last beat instead of wrapping
               if (last_beat) data_d = line_d;
               else           beat_d = beat_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
      req_valid_d    = (state_d == REQ);
      req_addr_d     = base_d + (ADDR_WIDTH'(beat_d) << BEAT_SHIFT);
      refill_valid_d = (state_d == DONE);
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         base_q         <= '0;
         beat_q         <= '0;
         line_q         <= '0;
         data_q         <= '0;
         cnt_q          <= '0;
         req_valid_q    <= 1'b0;
         req_addr_q     <= '0;
         refill_valid_q <= 1'b0;
      end else begin
         base_q         <= base_d;
         beat_q         <= beat_d;
         line_q         <= line_d;
         data_q         <= data_d;
         cnt_q          <= cnt_d;
         req_valid_q    <= req_valid_d;
         req_addr_q     <= req_addr_d;
         refill_valid_q <= refill_valid_d;
      end
   end

   assign bus.mem_req_valid_o       = req_valid_q;
   assign bus.mem_req_addr_o        = req_addr_q;
   assign bus.refill_icache_valid_o = refill_valid_q;
   assign bus.refill_icache_data_o  = data_q;
   assign bus.miss_cnt_o            = cnt_q;
   assign bus.busy_o                = (state_q != IDLE);

endmodule

// File: doc/icache_refill_unit.md
ICACHE_REFILL_UNIT -- requirements
Module: icache_refill_unit

Interface
REQ-001 The block SHALL have parameters: LINE_SIZE, default 512, refill line width in bits.
REQ-002 The block SHALL have parameters: BEAT_WIDTH, default 64, memory beat width in bits; BEATS = LINE_SIZE/BEAT_WIDTH (8).
REQ-003 The block SHALL have parameters: ADDR_WIDTH, default 64, physical address width.
REQ-004 Ports SHALL be, clock and reset first: clk  in  1  sole clock; rst  in  1  reset, synchronous, active-high.
REQ-005 Miss side SHALL be: icache_miss_valid_i  in  1  miss request; icache_miss_addr_i  in  ADDR_WIDTH  miss PC.
REQ-006 Refill side SHALL be: refill_icache_valid_o  out  1  one-cycle line-ready pulse; refill_icache_data_o  out  LINE_SIZE  assembled line.
REQ-007 Memory request SHALL be: mem_req_valid_o  out  1; mem_req_ready_i  in  1; mem_req_addr_o  out  ADDR_WIDTH  beat address.
REQ-008 Memory response SHALL be: mem_resp_valid_i  in  1; mem_resp_data_i  in  BEAT_WIDTH.
REQ-009 Status SHALL be: busy_o  out  1  FSM not IDLE; miss_cnt_o  out  32  accepted-miss count.

Function
REQ-010 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-011 In IDLE, icache_miss_valid_i SHALL be accepted; line base = addr with low log2(LINE_SIZE/8) bits (6) cleared is latched, beat counter cleared, next state REQ.
REQ-012 A miss asserted outside IDLE SHALL be ignored (no state, counter, or output effect).
REQ-013 In REQ, mem_req_valid_o SHALL be 1 with mem_req_addr_o = base + beat_cnt*(BEAT_WIDTH/8); valid and addr SHALL hold stable until mem_req_ready_i.
REQ-014 A request handshake (valid & ready) SHALL move REQ -> WAIT; exactly one request SHALL be outstanding.
REQ-015 In WAIT, mem_resp_valid_i SHALL write mem_resp_data_i into line bits [BEAT_WIDTH*k +: BEAT_WIDTH], k = beat_cnt, and increment beat_cnt.
REQ-016 After the response for beat BEATS-1, the next state SHALL be DONE; otherwise REQ.
REQ-017 mem_resp_valid_i outside WAIT SHALL be ignored.
REQ-018 In DONE, refill_icache_valid_o SHALL be 1 for exactly one cycle; the next state SHALL be IDLE.
REQ-019 refill_icache_data_o SHALL be registered and hold the last completed line until the next DONE.
REQ-020 Latency: miss accepted in cycle t -> first mem_req_valid_o in t+1. Last response in cycle u -> refill pulse in u+1. IDLE in u+2, so a new miss is accepted in u+2.
REQ-021 beat_cnt SHALL be log2(BEATS) bits; it SHALL be cleared on miss acceptance and never wrap during a line.
REQ-022 miss_cnt_o SHALL increment by 1 per accepted miss and saturate at 32'hFFFF_FFFF.
REQ-023 busy_o SHALL be combinational (state != IDLE).

Reset
REQ-024 rst SHALL be sampled only at a clk edge and SHALL force, mid-operation included: state IDLE, beat_cnt 0, miss_cnt_o 0, refill_icache_valid_o 0, mem_req_valid_o 0, line register 0.
REQ-025 A response arriving in the cycle rst is asserted SHALL be discarded.
REQ-026 After reset, no refill pulse SHALL be produced for a miss accepted before reset.

Structure
REQ-027 LINE_SIZE, BEAT_WIDTH, ADDR_WIDTH and the FSM state encoding SHALL live in the shared frontend package, so they are common with the icache.
REQ-028 The block SHALL be a single module; it SHALL contain no sub-module, since beat assembly is an in-module shift/indexed register.

Verification
REQ-029 Scenario 1: miss addr 0x8000_1234, ready=1, resp 1 cycle after each grant with data 0x11..0x88 -> request addresses 0x8000_1200..0x8000_1238 step 8; one refill pulse; data[63:0]=0x11, data[511:448]=0x88.
REQ-030 Scenario 2: ready held 0 for 5 cycles on beat 3 -> mem_req_addr_o stable at base+0x18 for all 5 cycles; line correct.
REQ-031 Scenario 3: second miss 0x9000_0000 during WAIT -> ignored; miss_cnt_o=1; only the first line is refilled.
REQ-032 Scenario 4: rst for 1 cycle during beat 5 WAIT -> IDLE next cycle; no refill pulse; miss_cnt_o=0; a fresh miss completes normally.
REQ-033 Scenario 5: spurious mem_resp_valid_i in IDLE with data 0xDEAD -> no state change; refill_icache_data_o unchanged.
REQ-034 Scenario 6: back-to-back misses, each issued in the cycle busy_o falls -> accepted; miss_cnt_o=2; 2 refill pulses, each separated by at least 16 cycles.
